// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle logic ops plus iterative
// unsigned shift-add multiply and restoring divide.
module alu_multicycle #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_SLT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] rhi_q, rhi_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_dbz;
  logic             sc_ill;
  logic             lt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic             last;

  assign lt = SIGNED_SLT ? ($signed(a) < $signed(b)) : (a < b);

  // One shift-add step: conditionally add the multiplicand, shift right.
  assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
  assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

  // One restoring step: shift in next dividend bit, keep diff if no borrow.
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_rem   = div_diff[WIDTH] ? div_shift[WIDTH-1:0]
                                     : div_diff[WIDTH-1:0];
  assign div_quo   = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};

  assign last = (cnt_q == CW'(WIDTH - 1));

  // Results of the ops that finish on the accept edge.
  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_dbz = 1'b0;
    sc_ill = 1'b0;
    case (alucontrol)
      3'b000: sc_res = {{(WIDTH-1){1'b0}}, lt};
      3'b001: sc_res = a - b;
      3'b011: begin
        sc_res = '1;
        sc_hi  = a;
        sc_dbz = 1'b1;
      end
      3'b100: sc_ill = 1'b1;
      3'b101: sc_res = a + b;
      3'b110: sc_res = a | b;
      3'b111: sc_res = a & b;
      default: sc_res = '0;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rhi_d   = rhi_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          if (alucontrol == 3'b010) begin
            state_d = MUL;
            opnd_d  = a;
            hi_d    = '0;
            lo_d    = b;
          end else if (alucontrol == 3'b011 && b != '0) begin
            state_d = DIV;
            opnd_d  = b;
            hi_d    = '0;
            lo_d    = a;
          end else begin
            state_d = DONE;
            res_d   = sc_res;
            rhi_d   = sc_hi;
            zero_d  = (sc_res == '0);
            dbz_d   = sc_dbz;
            ill_d   = sc_ill;
          end
        end
      end
      MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = mul_lo;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          res_d   = mul_lo;
          rhi_d   = mul_sum[WIDTH:1];
          zero_d  = (mul_lo == '0);
          dbz_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      DIV: begin
        hi_d  = div_rem;
        lo_d  = div_quo;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          res_d   = div_quo;
          rhi_d   = div_rem;
          zero_d  = (div_quo == '0);
          dbz_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rhi_q   <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rhi_q   <= rhi_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = res_q;
  assign result_hi   = rhi_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: vector table through a scoreboard,
// plus reset-abort, back-to-back, unsigned-slt and 8-bit builds.
module tb_alu_multicycle;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance: WIDTH 32, signed slt
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic [31:0] result, result_hi;
  logic        zero, dbz, ill;

  alu_multicycle #(.WIDTH(32), .SIGNED_SLT(1'b1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alucontrol(op), .out_valid(out_valid),
    .result(result), .result_hi(result_hi), .zero(zero),
    .div_by_zero(dbz), .illegal_op(ill)
  );

  // unsigned slt instance
  logic        s0_valid = 1'b0;
  logic        s0_ready;
  logic [31:0] s0_a = '0, s0_b = '0;
  logic [2:0]  s0_op = '0;
  logic        s0_ov;
  logic [31:0] s0_res, s0_hi;
  logic        s0_zero, s0_dbz, s0_ill;

  alu_multicycle #(.WIDTH(32), .SIGNED_SLT(1'b0)) u_s0 (
    .clk(clk), .reset(reset), .in_valid(s0_valid), .in_ready(s0_ready),
    .a(s0_a), .b(s0_b), .alucontrol(s0_op), .out_valid(s0_ov),
    .result(s0_res), .result_hi(s0_hi), .zero(s0_zero),
    .div_by_zero(s0_dbz), .illegal_op(s0_ill)
  );

  // 8-bit instance
  logic       w8_valid = 1'b0;
  logic       w8_ready;
  logic [7:0] w8_a = '0, w8_b = '0;
  logic [2:0] w8_op = '0;
  logic       w8_ov;
  logic [7:0] w8_res, w8_hi;
  logic       w8_zero, w8_dbz, w8_ill;

  alu_multicycle #(.WIDTH(8), .SIGNED_SLT(1'b1)) u_w8 (
    .clk(clk), .reset(reset), .in_valid(w8_valid), .in_ready(w8_ready),
    .a(w8_a), .b(w8_b), .alucontrol(w8_op), .out_valid(w8_ov),
    .result(w8_res), .result_hi(w8_hi), .zero(w8_zero),
    .div_by_zero(w8_dbz), .illegal_op(w8_ill)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        dz;
    logic        il;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        dz;
    logic        il;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop and compare on every out_valid; busy means not ready.
  always @(negedge clk) begin
    if (reset) begin
      if (sb.size() != 0)
        chk("busy_not_ready", {63'd0, in_ready}, 64'd0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", {32'd0, result}, {32'd0, e.res});
          chk("result_hi", {32'd0, result_hi}, {32'd0, e.hi});
          chk("flags", {61'd0, zero, dbz, ill}, {61'd0, e.z, e.dz, e.il});
          chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
        end
      end
    end
  end

  task automatic send(input vec_t v, input bit push, input bit hold);
    int n;
    exp_t e;
    @(negedge clk);
    op = v.op;
    a = v.a;
    b = v.b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
    end else begin
      @(posedge clk);
      #1;
      if (push) begin
        e.res = v.res;
        e.hi  = v.hi;
        e.z   = v.z;
        e.dz  = v.dz;
        e.il  = v.il;
        e.lat = (v.op == 3'b010 || (v.op == 3'b011 && v.b != 0)) ? 33 : 1;
        e.acc = cyc;
        sb.push_back(e);
      end
    end
    if (!hold) in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] x,
                              input logic [31:0] y, input logic [31:0] r,
                              input logic [31:0] h, input logic z,
                              input logic dz, input logic il);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r; v.hi = h;
    v.z = z; v.dz = dz; v.il = il;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int n;
    tbl.push_back(mk(3'b000, 32'd12, 32'd25, 32'd1, 0, 0, 0, 0));
    tbl.push_back(mk(3'b000, 32'd52, 32'd25, 32'd0, 0, 1, 0, 0));
    tbl.push_back(mk(3'b000, 32'd7, 32'd7, 32'd0, 0, 1, 0, 0));
    tbl.push_back(mk(3'b000, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 32'd15, 32'd25, 32'd4294967286, 0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 32'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 0, 0));
    tbl.push_back(mk(3'b110, 32'd0, 32'd0, 32'd0, 0, 1, 0, 0));
    tbl.push_back(mk(3'b110, 32'hF0F0, 32'h0F0F, 32'hFFFF, 0, 0, 0, 0));
    tbl.push_back(mk(3'b111, 32'd25, 32'd25, 32'd25, 0, 0, 0, 0));
    tbl.push_back(mk(3'b111, 32'hF0F0, 32'h0F0F, 32'd0, 0, 1, 0, 0));
    tbl.push_back(mk(3'b101, 32'd25, 32'd25, 32'd50, 0, 0, 0, 0));
    tbl.push_back(mk(3'b101, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 1, 0, 0));
    tbl.push_back(mk(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                     32'hFFFFFFFE, 0, 0, 0));
    tbl.push_back(mk(3'b010, 32'd7, 32'd9, 32'd63, 0, 0, 0, 0));
    tbl.push_back(mk(3'b010, 32'h10000, 32'h10000, 32'd0, 32'd1, 1, 0, 0));
    tbl.push_back(mk(3'b011, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0));
    tbl.push_back(mk(3'b011, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 0, 1, 0));
    tbl.push_back(mk(3'b011, 32'd3, 32'd10, 32'd0, 32'd3, 1, 0, 0));
    tbl.push_back(mk(3'b011, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 0, 0, 0, 0));
    tbl.push_back(mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 0));
    tbl.push_back(mk(3'b100, 32'd5, 32'd6, 32'd0, 32'd0, 1, 0, 1));

    // reset state
    #2 reset = 1'b0;
    #1;
    chk("reset_ctl", {59'd0, in_ready, out_valid, zero, dbz, ill},
        64'b10000);
    chk("reset_res", {result_hi, result}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // table vectors through the scoreboard
    foreach (tbl[i]) send(tbl[i], 1'b1, 1'b0);

    // reset in the middle of a multiply aborts it
    send(mk(3'b010, 32'd7, 32'd9, 32'd63, 0, 0, 0, 0), 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_ctl", {59'd0, in_ready, out_valid, zero, dbz, ill},
        64'b10000);
    chk("midreset_res", {result_hi, result}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    send(mk(3'b101, 32'd25, 32'd25, 32'd50, 0, 0, 0, 0), 1'b1, 1'b0);
    repeat (40) @(negedge clk);

    // back-to-back with in_valid held; mul must ignore the add operands
    send(mk(3'b010, 32'd3, 32'd5, 32'd15, 0, 0, 0, 0), 1'b1, 1'b1);
    send(mk(3'b101, 32'd10, 32'd20, 32'd30, 0, 0, 0, 0), 1'b1, 1'b1);
    send(mk(3'b100, 32'd1, 32'd2, 32'd0, 0, 1, 0, 1), 1'b1, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // unsigned slt build
    @(negedge clk);
    s0_a = 32'hFFFFFFFF;
    s0_b = 32'd1;
    s0_op = 3'b000;
    s0_valid = 1'b1;
    @(posedge clk);
    #1;
    s0_valid = 1'b0;
    chk("s0_slt", {61'd0, s0_ov, s0_res[0], s0_zero}, 64'b101);

    // 8-bit build: mul 200*200 and wrapping add
    @(negedge clk);
    w8_a = 8'd200;
    w8_b = 8'd200;
    w8_op = 3'b010;
    w8_valid = 1'b1;
    @(posedge clk);
    #1;
    w8_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (w8_ov) break;
    end
    chk("w8_mul_lat", 64'(n), 64'd9);
    chk("w8_mul", {48'd0, w8_hi, w8_res}, 64'h9C40);
    @(negedge clk);
    w8_a = 8'd255;
    w8_b = 8'd1;
    w8_op = 3'b101;
    w8_valid = 1'b1;
    @(posedge clk);
    #1;
    w8_valid = 1'b0;
    chk("w8_add", {54'd0, w8_ov, w8_zero, w8_res}, {54'd0, 2'b11, 8'd0});

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
